// File: rtl/pix_window_3x3.sv
// ============================================================================
// Module   : pix_window_3x3
// Brief    : Streaming 3x3 neighbourhood generator with two line buffers and
//            a single registered valid/ready output stage. Optional out_eof
//            port enabled by defining PIX_WINDOW_EOF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pix_window_3x3 #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 48,
    parameter int PIX_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] a,
    output logic [PIX_W-1:0] b,
    output logic [PIX_W-1:0] c,
    output logic [PIX_W-1:0] d,
    output logic [PIX_W-1:0] e,
    output logic [PIX_W-1:0] f,
    output logic [PIX_W-1:0] g,
    output logic [PIX_W-1:0] h,
    output logic [PIX_W-1:0] orig
`ifdef PIX_WINDOW_EOF_EN
    ,
    output logic             out_eof
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] c_COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] c_ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] c_COL_TWO  = CW'(2);
    localparam logic [RW-1:0] c_ROW_TWO  = RW'(2);

    // Position counters
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col_nxt;
    logic [RW-1:0] w_row_nxt;

    // Line buffers: r_lb1 holds row-1, r_lb2 holds row-2, both indexed by column
    logic [PIX_W-1:0] r_lb1 [IMG_WIDTH];
    logic [PIX_W-1:0] r_lb2 [IMG_WIDTH];
    logic [PIX_W-1:0] w_top;
    logic [PIX_W-1:0] w_mid;

    // Window history: *1 is column col-2, *2 is column col-1
    logic [PIX_W-1:0] r_t1, r_t2;
    logic [PIX_W-1:0] r_m1, r_m2;
    logic [PIX_W-1:0] r_b1, r_b2;

    // Output register
    logic             r_out_valid;
    logic [PIX_W-1:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h, r_orig;

    logic w_acc;
    logic w_emit;

    assign in_ready = !r_out_valid || out_ready;
    assign w_acc    = in_valid && in_ready;

    always_comb begin
        w_col     = in_sof ? '0 : r_col;
        w_row     = in_sof ? '0 : r_row;
        w_col_nxt = w_col + CW'(1);
        w_row_nxt = w_row;
        if (w_col == c_COL_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == c_ROW_LAST) ? '0 : w_row + RW'(1);
        end
    end

    assign w_emit = w_acc && (w_col >= c_COL_TWO) && (w_row >= c_ROW_TWO);

    assign w_top = r_lb2[w_col];
    assign w_mid = r_lb1[w_col];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

    // RAM-style storage without reset; rows 0 and 1 of each frame refill it
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb1[w_col] <= in_pix;
            r_lb2[w_col] <= w_mid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_t1 <= '0;
            r_t2 <= '0;
            r_m1 <= '0;
            r_m2 <= '0;
            r_b1 <= '0;
            r_b2 <= '0;
        end else if (w_acc) begin
            r_t1 <= r_t2;
            r_t2 <= w_top;
            r_m1 <= r_m2;
            r_m2 <= w_mid;
            r_b1 <= r_b2;
            r_b2 <= in_pix;
        end
    end

    // w_emit already implies the output stage is free or being drained
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_e         <= '0;
            r_f         <= '0;
            r_g         <= '0;
            r_h         <= '0;
            r_orig      <= '0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_a         <= r_t1;
            r_b         <= r_t2;
            r_c         <= w_top;
            r_d         <= r_m1;
            r_orig      <= r_m2;
            r_e         <= w_mid;
            r_f         <= r_b1;
            r_g         <= r_b2;
            r_h         <= in_pix;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef PIX_WINDOW_EOF_EN
    logic r_eof;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_eof <= 1'b0;
        end else if (w_emit) begin
            r_eof <= (w_col == c_COL_LAST) && (w_row == c_ROW_LAST);
        end
    end

    assign out_eof = r_eof;
`endif

    assign out_valid = r_out_valid;
    assign a         = r_a;
    assign b         = r_b;
    assign c         = r_c;
    assign d         = r_d;
    assign e         = r_e;
    assign f         = r_f;
    assign g         = r_g;
    assign h         = r_h;
    assign orig      = r_orig;

endmodule

`default_nettype wire

// File: tb/tb_pix_window_3x3.sv
// ============================================================================
// Module   : tb_pix_window_3x3
// Brief    : Scoreboard bench for pix_window_3x3 on a 4x4 image; pixel value
//            is base + row*16 + col. Checks out_eof when PIX_WINDOW_EOF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pix_window_3x3;

    localparam int W = 4;
    localparam int H = 4;

    typedef struct packed {
        logic [7:0] a, b, c, d, e, f, g, h, o;
        logic       eof;
    } win_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_pix = '0;
    logic       in_sof = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] a, b, c, d, e, f, g, h, orig;
`ifdef PIX_WINDOW_EOF_EN
    logic       out_eof;
`endif

    win_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_win = 0;

    pix_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .orig(orig)
`ifdef PIX_WINDOW_EOF_EN
        , .out_eof(out_eof)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] P(input logic [7:0] base, input int cc, input int rr);
        return base + 8'(rr * 16 + cc);
    endfunction

    // Monitor: consume windows on the handshake, compare with the scoreboard head
    initial begin
        win_t w;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && out_valid && out_ready) begin
                n_win++;
                if (q.size() == 0) begin
                    check("unexpected window orig", {24'd0, orig}, 32'hFFFF_FFFF);
                end else begin
                    w = q.pop_front();
                    check("win a", a, w.a);
                    check("win b", b, w.b);
                    check("win c", c, w.c);
                    check("win d", d, w.d);
                    check("win e", e, w.e);
                    check("win f", f, w.f);
                    check("win g", g, w.g);
                    check("win h", h, w.h);
                    check("win orig", orig, w.o);
`ifdef PIX_WINDOW_EOF_EN
                    check("win out_eof", out_eof, w.eof);
`endif
                end
            end
        end
    end

    task automatic send(input logic [7:0] pix, input logic sof);
        bit   done = 0;
        logic rdy;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_pix   = pix;
            in_sof   = sof;
            #2;
            rdy = in_ready;
            @(posedge clk);
            if (rdy) done = 1;
        end
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (!done) check("send timeout", 0, 1);
    endtask

    task automatic send_at(input logic [7:0] base, input int cc, input int rr,
                           input logic sof, input bit chkv);
        win_t w;
        if (cc >= 2 && rr >= 2) begin
            w.a = P(base, cc-2, rr-2); w.b = P(base, cc-1, rr-2); w.c = P(base, cc, rr-2);
            w.d = P(base, cc-2, rr-1); w.o = P(base, cc-1, rr-1); w.e = P(base, cc, rr-1);
            w.f = P(base, cc-2, rr);   w.g = P(base, cc-1, rr);   w.h = P(base, cc, rr);
            w.eof = (cc == W-1) && (rr == H-1);
            q.push_back(w);
        end
        send(P(base, cc, rr), sof);
        if (chkv) check("out_valid after accept", out_valid, (cc >= 2 && rr >= 2));
    endtask

    task automatic send_pixels(input logic [7:0] base, input int npix,
                               input logic sof, input bit chkv);
        for (int i = 0; i < npix; i++)
            send_at(base, i % W, i / W, sof && (i == 0), chkv);
    endtask

    task automatic drain_and_count(input string name, input int exp_win, input int start);
        for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check({name, " leftover"}, q.size(), 0);
        check({name, " window count"}, n_win - start, exp_win);
    endtask

    task automatic stall_ctl();
        logic [7:0] s_a, s_h, s_o;
        bit         seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            #3;
            if (out_valid) seen = 1;
        end
        if (!seen) check("stall wait timeout", 0, 1);
        s_a = a; s_h = h; s_o = orig;
        check("stall orig", s_o, 8'h11);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #3;
            check("stall in_ready", in_ready, 0);
            check("stall out_valid", out_valid, 1);
            check("stall a hold", a, s_a);
            check("stall h hold", h, s_h);
            check("stall orig hold", orig, s_o);
        end
        @(negedge clk);
        out_ready = 1'b1;
    endtask

    initial begin
        int s;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset orig", orig, 0);
        check("reset a", a, 0);
        check("reset in_ready", in_ready, 1);

        // 1: first frame, latency and content
        s = n_win;
        send_pixels(8'h00, W*H, 1'b1, 1'b1);
        drain_and_count("t1", 4, s);

        // 2: backpressure on the orig=11 window
        s = n_win;
        @(negedge clk);
        out_ready = 1'b0;
        fork
            send_pixels(8'h00, W*H, 1'b0, 1'b0);
            stall_ctl();
        join
        drain_and_count("t2", 4, s);

        // 3: two back-to-back frames without in_sof
        s = n_win;
        send_pixels(8'h00, W*H, 1'b0, 1'b0);
        send_pixels(8'h80, W*H, 1'b0, 1'b0);
        drain_and_count("t3", 8, s);

        // 4: in_sof at (1,2) abandons the partial frame
        s = n_win;
        send_pixels(8'h40, 2*W + 1, 1'b0, 1'b0);
        send_pixels(8'hC0, W*H, 1'b1, 1'b0);
        drain_and_count("t4", 4, s);

        // 5: reset while a window is pending
        s = n_win;
        @(negedge clk);
        out_ready = 1'b0;
        send_pixels(8'h00, 2*W + 3, 1'b0, 1'b0);
        @(negedge clk);
        check("t5 pending valid", out_valid, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t5 out_valid", out_valid, 0);
        check("t5 orig", orig, 0);
        check("t5 a", a, 0);
        check("t5 h", h, 0);
        check("t5 in_ready", in_ready, 1);
        q.delete();
        out_ready = 1'b1;
        send_pixels(8'h50, W*H, 1'b0, 1'b0);
        drain_and_count("t5", 4, s);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
